// File: rtl/addsub_serial.sv
// Multi-cycle two's-complement add/subtract, CHUNK bits per clock,
// with valid/ready handshakes and carry, overflow and zero flags.
module addsub_serial #(
  parameter int WIDTH = 24,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("addsub_serial: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             valid_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK:0]   sum_c;
  logic             cin_msb;
  logic             last;
  logic [WIDTH-1:0] result_d;

  // Operands shift right one chunk per cycle; the result fills from the top.
  always_comb begin
    a_c      = a_q[CHUNK-1:0];
    b_c      = b_q[CHUNK-1:0];
    sum_c    = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
    cin_msb  = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ sum_c[CHUNK-1];
    last     = (idx_q == IW'(N - 1));
    result_d = (result_q >> CHUNK)
             | (WIDTH'(sum_c[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            idx_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q      <= a_q >> CHUNK;
          b_q      <= b_q >> CHUNK;
          carry_q  <= sum_c[CHUNK];
          result_q <= result_d;
          idx_q    <= idx_q + 1'b1;
          if (last) begin
            cout_q  <= sum_c[CHUNK];
            ovf_q   <= cin_msb ^ sum_c[CHUNK];
            zero_q  <= (result_d == '0);
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = valid_q;
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three widths checked every cycle against an
// arithmetic reference, plus directed literal cases on the default build.
module tb_addsub_serial;

  typedef struct packed {
    logic        z;
    logic        v;
    logic        c;
    logic [31:0] r;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [34:0] want;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        iv[3];
  logic        ordy[3];
  logic        sb[3];
  logic [31:0] av[3];
  logic [31:0] bv[3];
  logic        ir[3];
  logic        ov[3];
  logic        co[3];
  logic        of[3];
  logic        zf[3];
  logic [23:0] r0;
  logic [31:0] r1;
  logic [15:0] r2;

  int tests;
  int fails;
  bit started;

  logic busy_m[3];
  logic valid_m[3];
  logic known_m[3];
  int   left_m[3];
  exp_t pend_m[3];
  exp_t out_m[3];

  addsub_serial #(.WIDTH(24), .CHUNK(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(av[0][23:0]), .b(bv[0][23:0]), .sub(sb[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .result(r0),
    .carry_out(co[0]), .overflow(of[0]), .zero(zf[0])
  );

  addsub_serial #(.WIDTH(32), .CHUNK(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(av[1]), .b(bv[1]), .sub(sb[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .result(r1),
    .carry_out(co[1]), .overflow(of[1]), .zero(zf[1])
  );

  addsub_serial #(.WIDTH(16), .CHUNK(16)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(av[2][15:0]), .b(bv[2][15:0]), .sub(sb[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .result(r2),
    .carry_out(co[2]), .overflow(of[2]), .zero(zf[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid(int d);
    case (d)
      0:       return 24;
      1:       return 32;
      default: return 16;
    endcase
  endfunction

  function automatic int nchk(int d);
    case (d)
      0:       return 3;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] dres(int d);
    case (d)
      0:       return {8'h0, r0};
      1:       return r1;
      default: return {16'h0, r2};
    endcase
  endfunction

  // Reference: exact integer arithmetic, then reduce modulo 2^w.
  function automatic exp_t ref_op(int w, logic [31:0] x, logic [31:0] y,
                                  logic s);
    exp_t            e;
    longint unsigned md, half, xa, ya, full;
    longint          sx, sy, sr;
    md   = 64'd1 << w;
    half = md >> 1;
    xa   = longint'(x) % md;
    ya   = longint'(y) % md;
    full = s ? xa + (md - ya) : xa + ya;
    sx   = (xa >= half) ? longint'(xa) - longint'(md) : longint'(xa);
    sy   = (ya >= half) ? longint'(ya) - longint'(md) : longint'(ya);
    sr   = s ? sx - sy : sx + sy;
    e.r  = 32'(full % md);
    e.c  = (full >= md);
    e.v  = (sr < -longint'(half)) || (sr >= longint'(half));
    e.z  = ((full % md) == 0);
    return e;
  endfunction

  task automatic chk(string nm, int d, logic [34:0] got, logic [34:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, d, $time, got, want);
    end
  endtask

  always @(posedge clk) begin
    started <= 1'b1;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        busy_m[d]  <= 1'b0;
        valid_m[d] <= 1'b0;
        left_m[d]  <= 0;
        out_m[d]   <= '0;
        known_m[d] <= 1'b1;
      end else if (!busy_m[d]) begin
        if (iv[d]) begin
          busy_m[d]  <= 1'b1;
          left_m[d]  <= nchk(d);
          pend_m[d]  <= ref_op(wid(d), av[d], bv[d], sb[d]);
          known_m[d] <= 1'b0;
        end
      end else if (left_m[d] > 0) begin
        left_m[d] <= left_m[d] - 1;
        if (left_m[d] == 1) begin
          valid_m[d] <= 1'b1;
          out_m[d]   <= pend_m[d];
          known_m[d] <= 1'b1;
        end
      end else if (ordy[d]) begin
        valid_m[d] <= 1'b0;
        busy_m[d]  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 3; d++) begin
        chk("in_ready", d, 35'(ir[d]), 35'(!busy_m[d] && !rst));
        chk("out_valid", d, 35'(ov[d]), 35'(valid_m[d]));
        if (known_m[d])
          chk("result_flags", d, {zf[d], of[d], co[d], dres(d)}, out_m[d]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op0(string nm, logic [31:0] x, logic [31:0] y, logic s,
                     logic [34:0] want);
    int n;
    n = 0;
    while (!ir[0] && n < 50) begin
      cyc();
      n++;
    end
    chk({nm, "_ready"}, 0, 35'(ir[0]), 35'(1));
    iv[0] = 1'b1;
    av[0] = x;
    bv[0] = y;
    sb[0] = s;
    cyc();
    iv[0] = 1'b0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!ov[0] && n < 40);
    chk({nm, "_latency"}, 0, 35'(n), 35'(3));
    chk(nm, 0, {zf[0], of[0], co[0], dres(0)}, want);
    ordy[0] = 1'b1;
    cyc();
    ordy[0] = 1'b0;
  endtask

  function automatic logic [31:0] pick(int w);
    logic [31:0] m;
    logic [31:0] v;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1);
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = m;
      2:       v = 32'h1 << (w - 1);
      3:       v = (32'h1 << (w - 1)) - 1;
      default: v = $urandom();
    endcase
    return v & m;
  endfunction

  task automatic rand_drive(int d, int cycles);
    for (int c = 0; c < cycles; c++) begin
      iv[d]   = ($urandom_range(0, 2) != 0);
      ordy[d] = ($urandom_range(0, 2) != 0);
      av[d]   = pick(wid(d));
      bv[d]   = ($urandom_range(0, 7) == 0) ? av[d] : pick(wid(d));
      sb[d]   = $urandom_range(0, 1) == 1;
      cyc();
    end
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
  endtask

  vec_t tv[6];
  exp_t e;
  int   n;

  initial begin
    tv[0] = '{"sub_basic", 32'h000005, 32'h000003, 1'b1, {3'b001, 32'h000002}};
    tv[1] = '{"borrow",    32'h000003, 32'h000005, 1'b1, {3'b000, 32'hFFFFFE}};
    tv[2] = '{"ovf_add",   32'h7FFFFF, 32'h000001, 1'b0, {3'b010, 32'h800000}};
    tv[3] = '{"ovf_sub",   32'h800000, 32'h000001, 1'b1, {3'b011, 32'h7FFFFF}};
    tv[4] = '{"zero_sub",  32'h123456, 32'h123456, 1'b1, {3'b101, 32'h000000}};
    tv[5] = '{"zero_add",  32'hFFFFFF, 32'h000001, 1'b0, {3'b101, 32'h000000}};
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b0;
      sb[d]   = 1'b0;
      av[d]   = '0;
      bv[d]   = '0;
    end
    for (int i = 0; i < 6; i++) begin
      e = ref_op(24, tv[i].a, tv[i].b, tv[i].s);
      chk({"model_", tv[i].nm}, 0, e, tv[i].want);
    end
    repeat (2) cyc();
    chk("reset_ready", 0, 35'(ir[0]), 35'(0));
    chk("reset_out", 0, {zf[0], of[0], co[0], dres(0)}, 35'(0));
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 6; i++)
      op0(tv[i].nm, tv[i].a, tv[i].b, tv[i].s, tv[i].want);

    // Backpressure with a competing operand set held on the input.
    op0("bp_first", 32'h000100, 32'h0000FF, 1'b1, {3'b001, 32'h000001});
    iv[0] = 1'b1;
    av[0] = 32'h000100;
    bv[0] = 32'h0000FF;
    sb[0] = 1'b1;
    cyc();
    av[0] = 32'hABCDEF;
    bv[0] = 32'h111111;
    sb[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 20) begin
      cyc();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_hold", 0, {zf[0], of[0], co[0], dres(0)}, {3'b001, 32'h000001});
      chk("bp_no_accept", 0, 35'(ir[0]), 35'(0));
    end
    ordy[0] = 1'b1;
    cyc();
    ordy[0] = 1'b0;
    chk("bp_ready_after", 0, 35'(ir[0]), 35'(1));
    cyc();
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 20) begin
      cyc();
      n++;
    end
    chk("bp_next", 0, {zf[0], of[0], co[0], dres(0)}, {3'b000, 32'hBCDF00});
    ordy[0] = 1'b1;
    cyc();
    ordy[0] = 1'b0;

    // Reset lands in the second RUN cycle; that operation must vanish.
    iv[0] = 1'b1;
    av[0] = 32'h000005;
    bv[0] = 32'h000003;
    sb[0] = 1'b0;
    cyc();
    iv[0] = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    chk("rst_ready_low", 0, 35'(ir[0]), 35'(0));
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rst_no_valid", 0, 35'(ov[0]), 35'(0));
      cyc();
    end
    op0("after_rst", 32'h000010, 32'h000001, 1'b1, {3'b001, 32'h00000F});

    fork
      rand_drive(0, 1500);
      rand_drive(1, 1500);
      rand_drive(2, 1500);
    join
    repeat (4) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle two's-complement add/subtract unit. It generalises the fixed 24-bit `a - b` datapath to any width, with a runtime add/sub mode and carry/borrow, signed-overflow and zero flags. It processes the operands CHUNK bits per clock and uses valid/ready handshakes on both sides. It sits between operand producers and result consumers in arithmetic pipelines where a full-width carry chain does not meet timing.

## Interface
- WIDTH, 24, operand/result width in bits; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 8, bits processed per clock; CHUNK == WIDTH gives single-cycle operation.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set a/b/sub is valid.
- in_ready  output  1  block can accept operands (IDLE only).
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- sub  input  1  0: a + b; 1: a - b.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  a + b or a - b, modulo 2^WIDTH.
- carry_out  output  1  carry out of MSB. Add: unsigned overflow. Sub: 1 = no borrow (a >= b unsigned).
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  result == 0.

## Operation
- N = WIDTH/CHUNK. States are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch a, b and sub; form b_op = sub ? ~b : b; set carry = sub (this supplies the +1 of the two's complement); clear chunk index; go to RUN.
- RUN:
  - Each cycle, chunk i = bits [i*CHUNK +: CHUNK] of result = a_chunk + b_op_chunk + carry; carry <= chunk carry-out; i <= i+1.
  - After chunk N-1, go to DONE.
- Flags on the final chunk:
  - carry_out = final carry.
  - overflow = carry into MSB XOR carry out of MSB.
  - zero = all result bits 0.
- DONE:
  - out_valid = 1; result and flags are held stable.
  - On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- Reset (any state, including mid-RUN): state = IDLE, index = 0, carry = 0, out_valid = 0, result = 0, carry_out = overflow = zero = 0. Partial work is discarded with no output.
- While rst = 1, in_ready = 0. It becomes 1 in the first cycle after rst deasserts.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Accept edge at cycle k. Chunks are processed at edges k+1 .. k+N. out_valid is high from cycle k+N until the out_ready handshake. Latency is N clocks; with defaults, N = 3.
- out_valid, result and flags are registered. in_ready is decoded from state only, with no combinational path from in_valid.
- When out_ready = 1 in DONE, the handshake completes at that edge: out_valid drops and in_ready rises the next cycle. Minimum issue interval is N+2 cycles.
- out_ready held low keeps DONE indefinitely; result and flags stay unchanged.
- out_ready asserted before out_valid has no effect.
- Reset takes priority over any handshake at the same edge.

## Test plan
- Basic subtract, defaults: sub=1, a=0x000005, b=0x000003.
  - Required: result=0x000002, carry_out=1, overflow=0, zero=0.
  - out_valid rises exactly 3 cycles after the accept edge.
- Borrow across all chunks: sub=1, a=0x000003, b=0x000005.
  - Required: result=0xFFFFFE, carry_out=0, overflow=0.
- Signed overflow, two cases:
  - sub=0, a=0x7FFFFF, b=0x000001: result=0x800000, overflow=1, carry_out=0.
  - sub=1, a=0x800000, b=0x000001: result=0x7FFFFF, overflow=1, carry_out=1.
- Zero flag and full carry chain, two cases:
  - sub=1, a=b=0x123456: result=0, zero=1, carry_out=1.
  - sub=0, a=0xFFFFFF, b=0x000001: result=0, zero=1, carry_out=1.
- Handshake and backpressure:
  - Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands. Required: result stable, in_ready=0, new operands not accepted.
  - Then out_ready=1 for 1 cycle. Required: in_ready=1 next cycle, and the next operation completes correctly.
- Reset and parameter sweep:
  - Assert rst for 1 cycle during the second RUN cycle. Required: out_valid never rises for that operation; the next operation is correct.
  - Repeat the random add/sub compare against a reference model for WIDTH=32/CHUNK=4 (latency 8) and WIDTH=16/CHUNK=16 (latency 1).
